bram_fifo: RTL and testbench

BRAM_FIFO -- requirements
Module: bram_fifo

---
 rtl/bram_fifo_pkg.sv | 18 +
 rtl/bram_fifo_bram.sv | 28 ++
 rtl/bram_fifo.sv | 104 ++++++++++
 tb/tb_bram_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bram_fifo_pkg.sv
// bram_fifo_pkg: default parameters and sizing helpers shared by the bram_fifo files.
package bram_fifo_pkg;

  localparam int unsigned DEF_WIDTH             = 32;
  localparam int unsigned DEF_LOG2_DEPTH        = 5;
  localparam int unsigned DEF_ALMOSTFULL_MARGIN = 4;

  // One slot is left unused so the entry count always fits in LOG2_DEPTH bits.
  function automatic int unsigned fifo_capacity(input int unsigned log2_depth);
    return (32'd1 << log2_depth) - 32'd1;
  endfunction

  function automatic int unsigned af_threshold(input int unsigned log2_depth,
                                               input int unsigned margin);
    return fifo_capacity(log2_depth) + 32'd1 - margin;
  endfunction

endpackage

// File: rtl/bram_fifo_bram.sv
// simple_dual_port_bram: one write port and one registered read port, intended
// to infer block RAM. The read register resets to zero.
module simple_dual_port_bram #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/bram_fifo.sv
// bram_fifo: single-clock FIFO over simple_dual_port_bram with registered flags.
// Define BRAM_FIFO_ERROR_FLAGS_EN to add sticky overflow/underflow outputs.
module bram_fifo
  import bram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH             = DEF_WIDTH,
  parameter int unsigned LOG2_DEPTH        = DEF_LOG2_DEPTH,
  parameter int unsigned ALMOSTFULL_MARGIN = DEF_ALMOSTFULL_MARGIN
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic                  almostfull,
  output logic                  empty,
  output logic [LOG2_DEPTH-1:0] count
`ifdef BRAM_FIFO_ERROR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [LOG2_DEPTH-1:0] CAPACITY = '1;
  localparam logic [LOG2_DEPTH:0]   AF_LEVEL =
    (LOG2_DEPTH+1)'(af_threshold(LOG2_DEPTH, ALMOSTFULL_MARGIN));

  logic [LOG2_DEPTH-1:0] wptr_q, wptr_d;
  logic [LOG2_DEPTH-1:0] rptr_q, rptr_d;
  logic [LOG2_DEPTH-1:0] count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  rvalid_q;
  logic                  wr_acc, rd_acc;

  // Flags are computed from the post-edge count so they register alongside it.
  always_comb begin
    wr_acc  = we && (count_q != CAPACITY);
    rd_acc  = re && !empty_q;
    wptr_d  = wptr_q + LOG2_DEPTH'(wr_acc);
    rptr_d  = rptr_q + LOG2_DEPTH'(rd_acc);
    count_d = count_q + LOG2_DEPTH'(wr_acc) - LOG2_DEPTH'(rd_acc);
    empty_d = (count_d == '0);
    af_d    = ({1'b0, count_d} >= AF_LEVEL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      rvalid_q <= rd_acc;
    end
  end

  simple_dual_port_bram #(
    .WIDTH  (WIDTH),
    .ADDR_W (LOG2_DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (wdata),
    .re_i    (rd_acc),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

  assign rvalid     = rvalid_q;
  assign almostfull = af_q;
  assign empty      = empty_q;
  assign count      = count_q;

`ifdef BRAM_FIFO_ERROR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (we && !wr_acc) overflow_q  <= 1'b1;
      if (re && !rd_acc) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_bram_fifo.sv
// tb_bram_fifo: queue-based reference model checked every cycle, plus directed
// vectors with literal expectations for bram_fifo at default parameters.
module tb_bram_fifo;

  localparam int W      = 32;
  localparam int L      = 5;
  localparam int MARGIN = 4;
  localparam int CAP    = (1 << L) - 1;
  localparam int AF_TH  = CAP + 1 - MARGIN;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          we, re;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata;
  logic          rvalid, almostfull, empty;
  logic [L-1:0]  count;
`ifdef BRAM_FIFO_ERROR_FLAGS_EN
  logic          overflow, underflow;
`endif

  bram_fifo #(
    .WIDTH             (W),
    .LOG2_DEPTH        (L),
    .ALMOSTFULL_MARGIN (MARGIN)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .we         (we),
    .wdata      (wdata),
    .re         (re),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .almostfull (almostfull),
    .empty      (empty),
    .count      (count)
`ifdef BRAM_FIFO_ERROR_FLAGS_EN
    ,
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of stored words plus the last popped word.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_rdata  = '0;
  bit           m_rvalid = 1'b0;
  bit           m_ovf    = 1'b0;
  bit           m_unf    = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_rdata  = '0;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
    end else begin
      automatic bit do_wr = we && (mq.size() < CAP);
      automatic bit do_rd = re && (mq.size() > 0);
      if (we && !do_wr) m_ovf = 1'b1;
      if (re && !do_rd) m_unf = 1'b1;
      m_rvalid = do_rd;
      if (do_rd) m_rdata = mq.pop_front();
      if (do_wr) mq.push_back(wdata);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_count",  count,      mq.size());
      check("cyc_empty",  empty,      mq.size() == 0);
      check("cyc_af",     almostfull, mq.size() >= AF_TH);
      check("cyc_rvalid", rvalid,     m_rvalid);
      check("cyc_rdata",  rdata,      m_rdata);
`ifdef BRAM_FIFO_ERROR_FLAGS_EN
      check("cyc_ovf",    overflow,   m_ovf);
      check("cyc_unf",    underflow,  m_unf);
`endif
    end
  end

  task automatic cyc(input logic w, input logic [W-1:0] d, input logic r);
    we    = w;
    wdata = d;
    re    = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    wdata   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",  count,      0);
    check("rst_empty",  empty,      1);
    check("rst_af",     almostfull, 0);
    check("rst_rvalid", rvalid,     0);
    check("rst_rdata",  rdata,      0);
    reset_n = 1'b1;
    chk_on  = 1'b1;

    // read on empty after reset
    cyc(1'b0, '0, 1'b1);
    check("unf_rvalid", rvalid, 0);
    check("unf_count",  count,  0);
`ifdef BRAM_FIFO_ERROR_FLAGS_EN
    check("unf_flag",   underflow, 1);
`endif

    // three writes then three reads
    cyc(1'b1, 32'h11, 1'b0);
    cyc(1'b1, 32'h22, 1'b0);
    cyc(1'b1, 32'h33, 1'b0);
    check("w3_count", count, 3);
    cyc(1'b0, '0, 1'b1);
    check("r1_rvalid", rvalid, 1);
    check("r1_rdata",  rdata,  32'h11);
    cyc(1'b0, '0, 1'b1);
    check("r2_rdata",  rdata,  32'h22);
    cyc(1'b0, '0, 1'b1);
    check("r3_rvalid", rvalid, 1);
    check("r3_rdata",  rdata,  32'h33);
    check("r3_empty",  empty,  1);
    cyc(1'b0, '0, 1'b0);
    check("idle_rvalid", rvalid, 0);
    check("idle_rdata",  rdata,  32'h33);

    // fill to capacity, then one dropped write
    for (int i = 0; i < CAP; i++) begin
      cyc(1'b1, 32'h1000 + i, 1'b0);
      if (i == AF_TH - 2) check("af_below", almostfull, 0);
      if (i == AF_TH - 1) check("af_at",    almostfull, 1);
    end
    check("full_count", count, 31);
    cyc(1'b1, 32'h1FFF, 1'b0);
    check("drop_count", count, 31);
`ifdef BRAM_FIFO_ERROR_FLAGS_EN
    check("ovf_flag",   overflow, 1);
`endif

    // drain to five entries
    for (int i = 0; i < 26; i++) cyc(1'b0, '0, 1'b1);
    check("drain_count", count, 5);
    check("drain_rdata", rdata, 32'h1019);

    // simultaneous read and write across the pointer wrap
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 32'h2000 + i, 1'b1);
      if (i == 0) check("rw_first_rdata", rdata, 32'h101A);
    end
    check("rw_count",      count, 5);
    check("rw_last_rdata", rdata, 32'h2004);

    // reach ten entries, pop once, then asynchronous reset mid-cycle
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h3000 + i, 1'b0);
    check("w10_count", count, 10);
    cyc(1'b0, '0, 1'b1);
    check("pre_rst_rvalid", rvalid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_count",  count,  0);
    check("arst_empty",  empty,  1);
    check("arst_rvalid", rvalid, 0);
    check("arst_rdata",  rdata,  0);
    #1;
    reset_n = 1'b1;
    we = 1'b0;
    re = 1'b0;
    @(posedge clk);
    #1;

    // write and read together on empty: read rejected
    cyc(1'b1, 32'hAB, 1'b1);
    check("wr_empty_count",  count,  1);
    check("wr_empty_rvalid", rvalid, 0);
    cyc(1'b0, '0, 1'b1);
    check("ab_rvalid", rvalid, 1);
    check("ab_rdata",  rdata,  32'hAB);
    check("ab_empty",  empty,  1);
`ifdef BRAM_FIFO_ERROR_FLAGS_EN
    check("ab_unf",    underflow, 1);
    check("ab_ovf",    overflow,  0);
`endif

    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
